// File: rtl/alu_op_sequencer.sv
// Hardwired T0..T6 control sequencer for one register-register ALU instruction on the Bus datapath.
// Strobes are decoded from the registered state and the latched IR; mul/div add a HI/LO write-back step.
module alu_op_sequencer #(
    parameter int               NREG       = 16,
    parameter int               OPC_W      = 5,
    parameter int               RF_W       = 4,
    parameter logic [OPC_W-1:0] MAX_ALU_OP = 5'd15,
    parameter logic [OPC_W-1:0] MUL_OP     = 5'd15,
    parameter logic [OPC_W-1:0] DIV_OP     = 5'd16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [31:0]       ir_bus,
    input  logic              mem_rdy,
    input  logic              alu_done,
    output logic [NREG-1:0]   reg_out,
    output logic [NREG-1:0]   reg_in,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zlowin,
    output logic              Zhighin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic [OPC_W-1:0]  alu_op,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IR_USED = OPC_W + 3 * RF_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_T6   = 3'd7;

    function automatic logic reg_ok(input logic [RF_W-1:0] r);
        return int'(r) < NREG;
    endfunction

    function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
        return (op == MUL_OP) || (op == DIV_OP);
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [RF_W-1:0] r);
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (int'(r) == i);
        end
        return v;
    endfunction

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [IR_USED-1:0] ir_q;
    logic               t1_first;

    logic [OPC_W-1:0] op_q, op_b;
    logic [RF_W-1:0]  ra_q, rb_q, rc_q, ra_b, rb_b, rc_b;
    logic             legal_b;
    logic             unused_ir_bits;

    assign op_q = ir_q[IR_USED-1 -: OPC_W];
    assign ra_q = ir_q[3*RF_W-1 -: RF_W];
    assign rb_q = ir_q[2*RF_W-1 -: RF_W];
    assign rc_q = ir_q[RF_W-1:0];

    // Legality is judged on the bus value being latched, since the IR only updates at the end of T2.
    assign op_b = ir_bus[31 -: OPC_W];
    assign ra_b = ir_bus[31-OPC_W -: RF_W];
    assign rb_b = ir_bus[31-OPC_W-RF_W -: RF_W];
    assign rc_b = ir_bus[31-OPC_W-2*RF_W -: RF_W];
    assign unused_ir_bits = ^ir_bus[31-IR_USED:0];

    assign legal_b = ((op_b <= MAX_ALU_OP) || is_muldiv(op_b))
                   && reg_ok(rb_b) && reg_ok(rc_b)
                   && (is_muldiv(op_b) || reg_ok(ra_b));

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            ir_q     <= '0;
            t1_first <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            t1_first <= (state == S_T0);
            done     <= ((state == S_T5) && !is_muldiv(op_q)) || (state == S_T6);
            err      <= (state == S_T2) && !legal_b;
            if (state == S_T2) begin
                ir_q <= ir_bus[31 -: IR_USED];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   if (mem_rdy) state_nxt = S_T2;
            S_T2:   state_nxt = legal_b ? S_T3 : S_IDLE;
            S_T3:   state_nxt = S_T4;
            S_T4:   if (alu_done) state_nxt = S_T5;
            S_T5:   state_nxt = is_muldiv(op_q) ? S_T6 : S_IDLE;
            S_T6:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        reg_out  = '0;
        reg_in   = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = t1_first;
                read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                reg_out = onehot(rb_q);
                Yin     = 1'b1;
            end
            // Z capture is gated by alu_done so the result is latched exactly once, in the completing cycle.
            S_T4: begin
                reg_out = onehot(rc_q);
                alu_op  = op_q;
                Zlowin  = alu_done;
                Zhighin = alu_done && is_muldiv(op_q);
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(op_q)) LOin = 1'b1;
                else                 reg_in = onehot(ra_q);
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
